// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the serial-in / parallel-out receiver.
//   deserState_e : receiver FSM states (StIdle, StShift)
//   DefaultWidth : default assembled word width in bits
package shift_deserializer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } deserState_e;

  localparam int unsigned DefaultWidth = 4;

endpackage

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver. Collects a framed bit stream into WIDTH-bit words and
// offers each word downstream through a single-entry valid/ready output buffer.
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-low reset
//   serialIn     : serial data bit, sampled when bitValid=1
//   bitValid     : qualifies serialIn this cycle
//   frameStart   : with bitValid, marks serialIn as the first bit of a new word
//   dataOut      : assembled word, held stable while dataValid=1
//   dataValid    : dataOut holds an unconsumed word
//   dataReady    : consumer accepts dataOut on an edge where dataValid=1
//   overrun      : sticky, a completed word was dropped because the buffer was full
//   clearOverrun : synchronous clear of overrun (a same-edge set wins)
//   busy         : a frame is partially assembled
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serialIn,
  input  logic             bitValid,
  input  logic             frameStart,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  input  logic             dataReady,
  output logic             overrun,
  input  logic             clearOverrun,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  deserState_e      stateQ, stateD;
  logic [WIDTH-1:0] shiftQ, shiftD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [WIDTH-1:0] dataQ, dataD;
  logic             validQ, validD;
  logic             overrunQ, overrunD;

  logic             acceptBit;
  logic             wordDone;
  logic             bufFree;
  logic [WIDTH-1:0] shiftBase;
  logic [WIDTH-1:0] nextWord;
  logic [CntW-1:0]  nextCnt;

  // Assembly FSM and shift register.
  always_comb begin
    stateD    = stateQ;
    shiftD    = shiftQ;
    cntD      = cntQ;
    wordDone  = 1'b0;
    // A frameStart bit is always accepted (start or resync); other bits only mid-frame.
    acceptBit = bitValid && (frameStart || (stateQ == StShift));
    // A resync discards the partial word, so the new frame shifts into a clean register.
    shiftBase = frameStart ? '0 : shiftQ;
    nextCnt   = frameStart ? CntW'(1) : cntQ + CntW'(1);
    if (MSB_FIRST) begin
      nextWord    = shiftBase << 1;
      nextWord[0] = serialIn;
    end else begin
      nextWord          = shiftBase >> 1;
      nextWord[WIDTH-1] = serialIn;
    end

    if (acceptBit) begin
      shiftD = nextWord;
      if (nextCnt == LastCnt) begin
        wordDone = 1'b1;
        stateD   = StIdle;
        cntD     = '0;
      end else begin
        stateD = StShift;
        cntD   = nextCnt;
      end
    end
  end

  // Output buffer and overrun flag.
  always_comb begin
    dataD    = dataQ;
    validD   = validQ;
    overrunD = overrunQ;
    bufFree  = !validQ || dataReady;

    if (wordDone && bufFree) begin
      dataD  = nextWord;
      validD = 1'b1;
    end else if (validQ && dataReady) begin
      validD = 1'b0;
    end

    if (wordDone && !bufFree) begin
      overrunD = 1'b1;
    end else if (clearOverrun) begin
      overrunD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= StIdle;
      shiftQ   <= '0;
      cntQ     <= '0;
      dataQ    <= '0;
      validQ   <= 1'b0;
      overrunQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      shiftQ   <= shiftD;
      cntQ     <= cntD;
      dataQ    <= dataD;
      validQ   <= validD;
      overrunQ <= overrunD;
    end
  end

  assign dataOut   = dataQ;
  assign dataValid = validQ;
  assign overrun   = overrunQ;
  assign busy      = (stateQ == StShift);

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  logic serialIn, bitValid, frameStart, dataReady, clearOverrun;

  logic [W-1:0] dataOutM, dataOutL;
  logic         dataValidM, dataValidL, overrunM, overrunL, busyM, busyL;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clk          (clk),
    .reset        (reset),
    .serialIn     (serialIn),
    .bitValid     (bitValid),
    .frameStart   (frameStart),
    .dataOut      (dataOutM),
    .dataValid    (dataValidM),
    .dataReady    (dataReady),
    .overrun      (overrunM),
    .clearOverrun (clearOverrun),
    .busy         (busyM)
  );

  shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clk          (clk),
    .reset        (reset),
    .serialIn     (serialIn),
    .bitValid     (bitValid),
    .frameStart   (frameStart),
    .dataOut      (dataOutL),
    .dataValid    (dataValidL),
    .dataReady    (dataReady),
    .overrun      (overrunL),
    .clearOverrun (clearOverrun),
    .busy         (busyL)
  );

  int nVectors     = 0;
  int nMiscompares = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    if (obs !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bits of the current frame kept in arrival order, word packed on completion.
  bit           mInFrame;
  bit           mBits[$];
  logic [W-1:0] mDataM, mDataL;
  bit           mValid, mOverrun;

  function automatic logic [W-1:0] packWord(input bit msbFirst);
    logic [W-1:0] w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (msbFirst) w[W-1-i] = mBits[i];
      else          w[i]     = mBits[i];
    end
    return w;
  endfunction

  task automatic modelReset();
    mInFrame = 0;
    mBits.delete();
    mDataM   = '0;
    mDataL   = '0;
    mValid   = 0;
    mOverrun = 0;
  endtask

  task automatic modelEdge();
    bit done    = 0;
    bit dropped = 0;
    logic [W-1:0] wM, wL;
    wM = '0;
    wL = '0;
    if (bitValid) begin
      if (frameStart) begin
        mBits.delete();
        mBits.push_back(serialIn);
        mInFrame = 1;
      end else if (mInFrame) begin
        mBits.push_back(serialIn);
      end
      if (mInFrame && mBits.size() == int'(W)) begin
        done     = 1;
        wM       = packWord(1'b1);
        wL       = packWord(1'b0);
        mInFrame = 0;
        mBits.delete();
      end
    end
    if (done && (!mValid || dataReady)) begin
      mDataM = wM;
      mDataL = wL;
      mValid = 1;
    end else begin
      if (done) dropped = 1;
      if (mValid && dataReady) mValid = 0;
    end
    if (dropped)           mOverrun = 1;
    else if (clearOverrun) mOverrun = 0;
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".dataOutM"},   32'(dataOutM),   32'(mDataM));
    checkVal({tag, ".dataOutL"},   32'(dataOutL),   32'(mDataL));
    checkVal({tag, ".dataValidM"}, 32'(dataValidM), 32'(mValid));
    checkVal({tag, ".dataValidL"}, 32'(dataValidL), 32'(mValid));
    checkVal({tag, ".overrunM"},   32'(overrunM),   32'(mOverrun));
    checkVal({tag, ".overrunL"},   32'(overrunL),   32'(mOverrun));
    checkVal({tag, ".busyM"},      32'(busyM),      32'(mInFrame));
    checkVal({tag, ".busyL"},      32'(busyL),      32'(mInFrame));
  endtask

  // One clock: inputs are applied 1 time unit after the previous edge, checked 1 after this one.
  task automatic step(input string tag, input logic sIn, input logic bv, input logic fs,
                      input logic rdy, input logic clr);
    serialIn     = sIn;
    bitValid     = bv;
    frameStart   = fs;
    dataReady    = rdy;
    clearOverrun = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  task automatic sendFrame(input string tag, input logic [3:0] bits, input int gap,
                           input logic rdy);
    for (int i = 0; i < 4; i++) begin
      step(tag, bits[3-i], 1'b1, (i == 0), rdy, 1'b0);
      for (int g = 0; g < gap; g++) step({tag, ".gap"}, 1'b1, 1'b0, 1'b0, rdy, 1'b0);
    end
  endtask

  initial begin
    serialIn     = 0;
    bitValid     = 0;
    frameStart   = 0;
    dataReady    = 0;
    clearOverrun = 0;

    // Reset
    reset = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    checkVal("reset.dataOutM", 32'(dataOutM), 0);
    reset = 1;

    // Basic frame 0,1,1,0 with dataReady=1
    sendFrame("basic", 4'b0110, 0, 1'b1);
    checkVal("basic.word", 32'(dataOutM), 6);
    checkVal("basic.valid", 32'(dataValidM), 1);
    step("basic.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("basic.validFall", 32'(dataValidM), 0);

    // Same bits with 3-cycle gaps
    sendFrame("gaps", 4'b0110, 3, 1'b1);
    checkVal("gaps.word", 32'(dataOutM), 6);
    step("gaps.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun with dataReady=0
    sendFrame("ovr6", 4'b0110, 0, 1'b0);
    sendFrame("ovr9", 4'b1001, 0, 1'b0);
    checkVal("ovr.word", 32'(dataOutM), 6);
    checkVal("ovr.flag", 32'(overrunM), 1);
    step("ovr.drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("ovr.validFall", 32'(dataValidM), 0);
    step("ovr.clear", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkVal("ovr.cleared", 32'(overrunM), 0);

    // Resync: two bits, then a fresh frame 1,0,0,1
    step("resync", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("resync", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    sendFrame("resync", 4'b1001, 0, 1'b1);
    checkVal("resync.word", 32'(dataOutM), 9);

    // Async reset mid-frame with a word pending
    step("preRst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("preRst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 reset = 0;
    modelReset();
    #1;
    checkAll("asyncRst");
    checkVal("asyncRst.busy", 32'(busyM), 0);
    @(posedge clk);
    #1 reset = 1;
    sendFrame("postRst", 4'b0110, 0, 1'b1);
    checkVal("postRst.word", 32'(dataOutM), 6);

    // Bit order: 1,0,0,0
    sendFrame("order", 4'b1000, 0, 1'b1);
    checkVal("order.lsbFirst", 32'(dataOutL), 1);
    checkVal("order.msbFirst", 32'(dataOutM), 8);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-in, parallel-out receiver and the counterpart of the ShiftRegister block. It collects a framed serial bit stream, one bit per qualified cycle, into WIDTH-bit words. Each completed word is held in an output register and offered downstream with a valid/ready handshake. A separate output buffer lets the next frame assemble while the previous word is still waiting; a word that arrives while the buffer is still full raises a sticky overrun flag.

Parameters:
WIDTH, 4, word width in bits (legal range 1..32)
MSB_FIRST, 1, 1: first received bit lands in dataOut[WIDTH-1]; 0: first bit lands in dataOut[0]

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
serialIn  input  1  serial data bit, sampled when bitValid=1
bitValid  input  1  qualifies serialIn this cycle
frameStart  input  1  with bitValid=1, marks serialIn as bit 0 of a new word
dataOut  output  WIDTH  assembled word, held while dataValid=1
dataValid  output  1  dataOut holds an unconsumed word
dataReady  input  1  consumer accepts dataOut on an edge where dataValid=1
overrun  output  1  sticky: a completed word was dropped
clearOverrun  input  1  synchronous clear of overrun
busy  output  1  a frame is partially assembled (state SHIFT)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, bit count=0, dataOut=0, dataValid=0, overrun=0, busy=0.
- State machine has two states, IDLE and SHIFT. The bit counter is $clog2(WIDTH+1) bits wide.
- IDLE:
  - bitValid=1 and frameStart=1: capture serialIn as the first bit, count=1, go to SHIFT.
  - bitValid without frameStart is ignored.
  - If WIDTH=1, the word completes on this edge and the state stays IDLE.
- SHIFT:
  - Each bitValid=1 cycle shifts serialIn in and increments count.
  - Cycles with bitValid=0 hold all state; gaps of any length are legal.
- Bit order:
  - MSB_FIRST=1: shift left, new bit at LSB; the first bit ends up in bit WIDTH-1.
  - MSB_FIRST=0: shift right, new bit at MSB; the first bit ends up in bit 0.
- Word completion, on the edge that accepts the WIDTH-th bit:
  - Go to IDLE and set count=0.
  - If the output buffer is free (dataValid=0, or dataValid=1 with dataReady=1 on the same edge), load dataOut and set dataValid=1. The word is visible immediately after that edge, so latency from last bit to dataValid is 0 cycles after the sampling edge.
  - Otherwise drop the new word, leave dataOut unchanged and set overrun=1.
- Handshake:
  - A word is consumed on an edge where dataValid=1 and dataReady=1.
  - dataValid then falls, unless a new word completes on the same edge; in that case dataValid stays 1 and dataOut takes the new word with no overrun.
  - dataOut must not change while dataValid=1 and dataReady=0.
- Resync: frameStart=1 with bitValid=1 while in SHIFT discards the partial word. That bit becomes the first bit of a new frame, count=1, and the state stays SHIFT. No overrun and no output change result.
- overrun:
  - Cleared by clearOverrun=1 on the next edge.
  - If a set and a clear occur on the same edge, set wins.
  - Cleared only by reset or clearOverrun.
- busy = (state == SHIFT).
- Reset asserted mid-frame or while a word is pending: everything clears asynchronously and the pending word is lost. After reset deasserts, the next frameStart begins cleanly.

Decomposition:
- Shared package: state typedef (IDLE, SHIFT) and the default word-width constant.
- Single module. The output buffer and overrun logic stay inline; no sub-module is warranted.

Test Plan:
- Reset check: hold reset=0 for 2 cycles -> dataOut=0, dataValid=0, overrun=0, busy=0.
- Basic frame, WIDTH=4, MSB_FIRST=1, dataReady=1: frameStart+bit 0, then bits 1,1,0 on consecutive cycles -> dataOut=6, dataValid=1 for exactly one cycle, busy=1 for 3 cycles.
- Gaps: same bits 0,1,1,0 with bitValid=0 for 3 cycles between each bit -> dataOut=6; no change during gaps.
- Overrun, dataReady=0: frame 6, then frame 9 (1,0,0,1) -> dataOut stays 6 and overrun=1. Then raise dataReady -> dataValid falls. Pulse clearOverrun -> overrun=0.
- Resync and reset, dataReady=1: send bits 1,1, then frameStart with bits 1,0,0,1 -> dataOut=9. Then drive reset=0 after 2 bits of a new frame -> busy=0, dataValid=0; the next full frame 6 produces dataOut=6.
- Bit order with MSB_FIRST=0: bits 1,0,0,0 -> dataOut=1. The same bits with MSB_FIRST=1 -> dataOut=8.
